// File: rtl/wdt_pkg.sv
// Shared types and sizes for the FSB bus-timeout watchdog.
package wdt_pkg;

    localparam int unsigned CW       = 8;
    localparam int unsigned FCW      = 4;
    localparam int unsigned AW       = 16;
    localparam int unsigned FCNT_MAX = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FAULT = 2'd2,
        DONE  = 2'd3
    } wdt_state_e;

    // Diagnostic record of the first bus timeout since reset
    typedef struct packed {
        logic           valid;
        logic [AW-1:0]  addr;
        logic [FCW-1:0] cnt;
    } fault_log_t;

endpackage

// File: rtl/fsb_watchdog_if.sv
// FSB-side signals observed by the watchdog plus its bus-error and fault-log outputs.
interface fsb_watchdog_if;
    import wdt_pkg::*;

    logic           BACT;
    logic           nAS_FSB;
    logic           nDTACK_FSB;
    logic           nVPA_FSB;
    logic           IOCS;
    logic           IACS;
    logic           E;
    logic [AW-1:0]  A_FSB;
    logic           WDBERR;
    logic           FaultValid;
    logic [AW-1:0]  FaultAddr;
    logic [FCW-1:0] FaultCnt;

    modport master (
        output BACT, nAS_FSB, nDTACK_FSB, nVPA_FSB, IOCS, IACS, E, A_FSB,
        input  WDBERR, FaultValid, FaultAddr, FaultCnt
    );

    modport slave (
        input  BACT, nAS_FSB, nDTACK_FSB, nVPA_FSB, IOCS, IACS, E, A_FSB,
        output WDBERR, FaultValid, FaultAddr, FaultCnt
    );

endinterface

// File: rtl/esync_edge.sv
// Two-flop synchronizer for an asynchronous level plus a rising-edge strobe (one clk wide).
module esync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d_async,
    output logic rise_c
);

    // sync_q[0]=E1, sync_q[1]=E2, sync_q[2]=E3
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], d_async};
        end
    end

    assign rise_c = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/fsb_watchdog.sv
// FSB bus-timeout watchdog: raises WDBERR when a BACT cycle outlives its class limit.
// Optional fault log built when WDT_FAULTLOG_EN is defined.
module fsb_watchdog
    import wdt_pkg::*;
#(
    parameter int unsigned FSB_TMO = 255,
    parameter int unsigned IO_TMO  = 20
) (
    input  logic          FCLK,
    input  logic          nRESin,
    fsb_watchdog_if.slave bus
);

    localparam logic [CW-1:0] FSB_LIM = CW'(FSB_TMO);
    localparam logic [CW-1:0] IO_LIM  = CW'(IO_TMO);

    if (FSB_LIM == '0 || IO_LIM == '0) begin : g_bad_limit
        $error("fsb_watchdog: FSB_TMO and IO_TMO[7:0] must be nonzero");
    end

    wdt_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          iocls_q, iocls_d;
    logic          wdberr_q, wdberr_d;
    logic          to_fault;
    logic          e_rise;
    logic          term;
    logic          tick;
    logic [CW-1:0] lim;

    esync_edge u_esync (
        .clk     (FCLK),
        .rst_n   (nRESin),
        .d_async (bus.E),
        .rise_c  (e_rise)
    );

    assign term = !bus.nDTACK_FSB || !bus.nVPA_FSB;
    assign tick = iocls_q ? e_rise : 1'b1;
    assign lim  = iocls_q ? IO_LIM : FSB_LIM;

    always_ff @(posedge FCLK or negedge nRESin) begin
        if (!nRESin) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            iocls_q  <= 1'b0;
            wdberr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            iocls_q  <= iocls_d;
            wdberr_q <= wdberr_d;
        end
    end

    // Termination beats abort beats limit; the limit is checked on the registered count
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        iocls_d  = iocls_q;
        to_fault = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.BACT && !term) begin
                    state_d = ARMED;
                    iocls_d = bus.IOCS || bus.IACS;
                    cnt_d   = '0;
                end
            end
            ARMED: begin
                if (term) begin
                    state_d = DONE;
                end else if (!bus.BACT) begin
                    state_d = IDLE;
                end else if (cnt_q == lim) begin
                    state_d  = FAULT;
                    to_fault = 1'b1;
                end else if (tick && cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FAULT: begin
                if (bus.nAS_FSB) state_d = DONE;
            end
            DONE: begin
                if (!bus.BACT) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        wdberr_d = (state_d == FAULT);
    end

    assign bus.WDBERR = wdberr_q;

`ifdef WDT_FAULTLOG_EN
    fault_log_t log_q, log_d;

    // First fault captures the address; every fault bumps the saturating count
    always_comb begin
        log_d = log_q;
        if (to_fault) begin
            if (!log_q.valid) begin
                log_d.valid = 1'b1;
                log_d.addr  = bus.A_FSB;
            end
            if (log_q.cnt != FCW'(FCNT_MAX)) begin
                log_d.cnt = log_q.cnt + FCW'(1);
            end
        end
    end

    always_ff @(posedge FCLK or negedge nRESin) begin
        if (!nRESin) begin
            log_q <= '0;
        end else begin
            log_q <= log_d;
        end
    end

    assign bus.FaultValid = log_q.valid;
    assign bus.FaultAddr  = log_q.addr;
    assign bus.FaultCnt   = log_q.cnt;
`else
    logic unused_log;
    assign unused_log     = ^{bus.A_FSB, to_fault};
    assign bus.FaultValid = 1'b0;
    assign bus.FaultAddr  = '0;
    assign bus.FaultCnt   = '0;
`endif

endmodule

// File: tb/tb_fsb_watchdog.sv
// Directed bench for fsb_watchdog (FSB_TMO=8, IO_TMO=3); log expectations follow WDT_FAULTLOG_EN.
module tb_fsb_watchdog;
    import wdt_pkg::*;

`ifdef WDT_FAULTLOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_cnt   = 0;
    logic        exp_valid = 1'b0;
    logic [15:0] exp_addr  = '0;

    fsb_watchdog_if bus ();

    fsb_watchdog #(.FSB_TMO(8), .IO_TMO(3)) dut (
        .FCLK   (clk),
        .nRESin (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.BACT       = 1'b0;
        bus.nAS_FSB    = 1'b1;
        bus.nDTACK_FSB = 1'b1;
        bus.nVPA_FSB   = 1'b1;
        bus.IOCS       = 1'b0;
        bus.IACS       = 1'b0;
        bus.E          = 1'b0;
        bus.A_FSB      = '0;
    endtask

    // Reference fault-log model
    task automatic log_fault(input logic [15:0] addr);
        if (LOG_EN) begin
            if (!exp_valid) begin
                exp_valid = 1'b1;
                exp_addr  = addr;
            end
            if (exp_cnt < 15) exp_cnt++;
        end
    endtask

    task automatic test_reset();
        bus_idle();
        rst_n = 1'b0;
        step();
        step();
        n_cmp++; if (bus.WDBERR !== 1'b0) begin n_bad++; $display("FAIL reset_wdberr: got %b want 0", bus.WDBERR); end
        n_cmp++; if (bus.FaultValid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.FaultValid); end
        n_cmp++; if (bus.FaultAddr !== 16'h0000) begin n_bad++; $display("FAIL reset_addr: got %h want 0000", bus.FaultAddr); end
        n_cmp++; if (bus.FaultCnt !== 4'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", bus.FaultCnt); end
        n_cmp++; if (dut.state_q !== IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, IDLE); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    // E high on steps 7..9 of each 10: rises sampled at edges 10/20/30, fault at edge 31
    task automatic test_io_timeout();
        int n;
        bus.A_FSB   = 16'hEFE1;
        bus.IOCS    = 1'b1;
        bus.BACT    = 1'b1;
        bus.nAS_FSB = 1'b0;
        n = 0;
        while (bus.WDBERR !== 1'b1 && n < 60) begin
            step();
            n++;
            bus.E = ((n % 10) >= 7);
        end
        n_cmp++; if (n !== 31) begin n_bad++; $display("FAIL io_latency: got %0d want 31", n); end
        log_fault(16'hEFE1);
        step();
        n_cmp++; if (bus.WDBERR !== 1'b1) begin n_bad++; $display("FAIL io_hold: got %b want 1", bus.WDBERR); end
        bus_idle();
        step();
        n_cmp++; if (bus.WDBERR !== 1'b0) begin n_bad++; $display("FAIL io_release: got %b want 0", bus.WDBERR); end
        n_cmp++; if (dut.state_q !== DONE) begin n_bad++; $display("FAIL io_done: got %0d want %0d", dut.state_q, DONE); end
        step();
        n_cmp++; if (bus.FaultAddr !== exp_addr) begin n_bad++; $display("FAIL io_addr: got %h want %h", bus.FaultAddr, exp_addr); end
        n_cmp++; if (bus.FaultValid !== exp_valid) begin n_bad++; $display("FAIL io_valid: got %b want %b", bus.FaultValid, exp_valid); end
    endtask

    task automatic test_fast_timeout();
        int n;
        bus.A_FSB   = 16'h1234;
        bus.BACT    = 1'b1;
        bus.nAS_FSB = 1'b0;
        n = 0;
        while (bus.WDBERR !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL fast_latency: got %0d want 10", n); end
        log_fault(16'h1234);
        step();
        n_cmp++; if (bus.WDBERR !== 1'b1) begin n_bad++; $display("FAIL fast_hold: got %b want 1", bus.WDBERR); end
        bus.nAS_FSB = 1'b1;
        step();
        n_cmp++; if (bus.WDBERR !== 1'b0) begin n_bad++; $display("FAIL fast_release: got %b want 0", bus.WDBERR); end
        n_cmp++; if (dut.state_q !== DONE) begin n_bad++; $display("FAIL fast_done: got %0d want %0d", dut.state_q, DONE); end
        bus.BACT = 1'b0;
        step();
        n_cmp++; if (dut.state_q !== IDLE) begin n_bad++; $display("FAIL fast_idle: got %0d want %0d", dut.state_q, IDLE); end
        n_cmp++; if (bus.FaultCnt !== 4'(exp_cnt)) begin n_bad++; $display("FAIL fast_cnt: got %0d want %0d", bus.FaultCnt, exp_cnt); end
        n_cmp++; if (bus.FaultAddr !== exp_addr) begin n_bad++; $display("FAIL fast_addr: got %h want %h", bus.FaultAddr, exp_addr); end
    endtask

    // DTACK at cycle 3, then BACT held well past the limit: DONE must not re-arm
    task automatic test_ram_cycle();
        logic seen;
        bus.A_FSB   = 16'h0040;
        bus.BACT    = 1'b1;
        bus.nAS_FSB = 1'b0;
        step();
        step();
        bus.nDTACK_FSB = 1'b0;
        step();
        n_cmp++; if (dut.state_q !== DONE) begin n_bad++; $display("FAIL ram_done: got %0d want %0d", dut.state_q, DONE); end
        bus.nDTACK_FSB = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            step();
            if (bus.WDBERR !== 1'b0) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL ram_no_berr: got %b want 0", seen); end
        n_cmp++; if (dut.state_q !== DONE) begin n_bad++; $display("FAIL ram_hold_done: got %0d want %0d", dut.state_q, DONE); end
        bus_idle();
        step();
        n_cmp++; if (dut.state_q !== IDLE) begin n_bad++; $display("FAIL ram_idle: got %0d want %0d", dut.state_q, IDLE); end
    endtask

    // DTACK sampled on the same edge the count sits at the limit
    task automatic test_same_cycle();
        bus.A_FSB   = 16'h0077;
        bus.BACT    = 1'b1;
        bus.nAS_FSB = 1'b0;
        repeat (9) step();
        n_cmp++; if (dut.state_q !== ARMED) begin n_bad++; $display("FAIL same_armed: got %0d want %0d", dut.state_q, ARMED); end
        bus.nDTACK_FSB = 1'b0;
        step();
        n_cmp++; if (bus.WDBERR !== 1'b0) begin n_bad++; $display("FAIL same_wdberr: got %b want 0", bus.WDBERR); end
        n_cmp++; if (dut.state_q !== DONE) begin n_bad++; $display("FAIL same_state: got %0d want %0d", dut.state_q, DONE); end
        n_cmp++; if (bus.FaultCnt !== 4'(exp_cnt)) begin n_bad++; $display("FAIL same_cnt: got %0d want %0d", bus.FaultCnt, exp_cnt); end
        bus_idle();
        step();
    endtask

    // One idle sample between cycles is enough to re-arm
    task automatic test_back_to_back();
        int n;
        bus.BACT    = 1'b1;
        bus.nAS_FSB = 1'b0;
        step();
        step();
        bus.nDTACK_FSB = 1'b0;
        step();
        bus_idle();
        step();
        bus.A_FSB   = 16'h00AA;
        bus.BACT    = 1'b1;
        bus.nAS_FSB = 1'b0;
        step();
        n_cmp++; if (dut.state_q !== ARMED) begin n_bad++; $display("FAIL b2b_armed: got %0d want %0d", dut.state_q, ARMED); end
        n = 1;
        while (bus.WDBERR !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL b2b_latency: got %0d want 10", n); end
        log_fault(16'h00AA);
        bus_idle();
        step();
        step();
    endtask

    task automatic test_saturation();
        int n;
        int faults;
        faults = 0;
        for (int i = 0; i < 20; i++) begin
            bus.A_FSB   = 16'h0100 + 16'(i);
            bus.BACT    = 1'b1;
            bus.nAS_FSB = 1'b0;
            n = 0;
            while (bus.WDBERR !== 1'b1 && n < 40) begin
                step();
                n++;
            end
            if (bus.WDBERR === 1'b1) faults++;
            log_fault(16'h0100 + 16'(i));
            bus_idle();
            step();
            step();
        end
        n_cmp++; if (faults !== 20) begin n_bad++; $display("FAIL sat_faults: got %0d want 20", faults); end
        n_cmp++; if (bus.FaultCnt !== 4'(exp_cnt)) begin n_bad++; $display("FAIL sat_cnt: got %0d want %0d", bus.FaultCnt, exp_cnt); end
        n_cmp++; if (bus.FaultAddr !== exp_addr) begin n_bad++; $display("FAIL sat_addr: got %h want %h", bus.FaultAddr, exp_addr); end
        n_cmp++; if (bus.FaultValid !== exp_valid) begin n_bad++; $display("FAIL sat_valid: got %b want %b", bus.FaultValid, exp_valid); end
    endtask

    task automatic test_reset_mid_fault();
        int n;
        bus.A_FSB   = 16'h5A5A;
        bus.BACT    = 1'b1;
        bus.nAS_FSB = 1'b0;
        n = 0;
        while (bus.WDBERR !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        n_cmp++; if (bus.WDBERR !== 1'b1) begin n_bad++; $display("FAIL rmf_fault: got %b want 1", bus.WDBERR); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.WDBERR !== 1'b0) begin n_bad++; $display("FAIL rmf_wdberr: got %b want 0", bus.WDBERR); end
        n_cmp++; if (bus.FaultValid !== 1'b0) begin n_bad++; $display("FAIL rmf_valid: got %b want 0", bus.FaultValid); end
        n_cmp++; if (bus.FaultAddr !== 16'h0000) begin n_bad++; $display("FAIL rmf_addr: got %h want 0000", bus.FaultAddr); end
        n_cmp++; if (bus.FaultCnt !== 4'd0) begin n_bad++; $display("FAIL rmf_cnt: got %0d want 0", bus.FaultCnt); end
        n_cmp++; if (dut.state_q !== IDLE) begin n_bad++; $display("FAIL rmf_state: got %0d want %0d", dut.state_q, IDLE); end
        exp_cnt   = 0;
        exp_valid = 1'b0;
        exp_addr  = '0;
        bus_idle();
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_io_timeout();
        test_fast_timeout();
        test_ram_cycle();
        test_same_cycle();
        test_back_to_back();
        test_saturation();
        test_reset_mid_fault();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
